// File: rtl/hazard_ctrl_v2.sv
// rtl/hazard_ctrl_v2.sv - EX forwarding, load-use stall, branch flush and data-memory wait control
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl_v2 #(
   parameter int REG_AW       = 5,
   parameter int FLUSH_CYCLES = 1,
   parameter int MEM_TIMEOUT  = 16,
   parameter int CNT_W        = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rs1D,
   input  logic [REG_AW-1:0] rs2D,
   input  logic [REG_AW-1:0] rs1E,
   input  logic [REG_AW-1:0] rs2E,
   input  logic [REG_AW-1:0] rdE,
   input  logic              regwriteE,
   input  logic              isloadE,
   input  logic [REG_AW-1:0] rdM,
   input  logic              regwriteM,
   input  logic              isloadM,
   input  logic [REG_AW-1:0] rdW,
   input  logic              regwriteW,
   input  logic              isbranchtakenE,
   input  logic              memreqM,
   input  logic              memreadyM,
   output logic [1:0]        forwardaE,
   output logic [1:0]        forwardbE,
   output logic              stallF,
   output logic              stallD,
   output logic              stallE,
   output logic              stallM,
   output logic              flushD,
   output logic              flushE,
   output logic              flushW,
   output logic              memtimeout,
   output logic [CNT_W-1:0]  stallcnt,
   output logic [CNT_W-1:0]  flushcnt
);

   typedef enum logic [1:0] {RUN, MEMWAIT, FLUSH} stateT;

   stateT      state;
   logic [7:0] waitCnt;
   logic [2:0] flushCntInt;
   logic       memMiss;
   logic       loadUse;

   // A miss is detected in the same cycle the M-stage access fails, so that cycle already stalls.
   assign memMiss = memreqM && !memreadyM;
   assign loadUse = isloadE && regwriteE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

   function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] rdMem,
                                         input logic              wrMem,
                                         input logic              ldMem,
                                         input logic [REG_AW-1:0] rdWb,
                                         input logic              wrWb);
      if (wrMem && !ldMem && (rdMem != '0) && (rdMem == rs))
         return 2'b10;
      else if (wrWb && (rdWb != '0) && (rdWb == rs))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   // Combinational control outputs: forwarding always, stalls/flushes by state with MEMWAIT > branch > load-use.
   always_comb begin
      forwardaE = 2'b00;
      forwardbE = 2'b00;
      stallF    = 1'b0;
      stallD    = 1'b0;
      stallE    = 1'b0;
      stallM    = 1'b0;
      flushD    = 1'b0;
      flushE    = 1'b0;
      flushW    = 1'b0;
      if (rst) begin
         forwardaE = fwdSel(rs1E, rdM, regwriteM, isloadM, rdW, regwriteW);
         forwardbE = fwdSel(rs2E, rdM, regwriteM, isloadM, rdW, regwriteW);
         case (state)
            RUN: begin
               if (memMiss) begin
                  {stallF, stallD, stallE, stallM, flushW} = 5'b11111;
               end else if (isbranchtakenE) begin
                  flushD = 1'b1;
                  flushE = 1'b1;
               end else if (loadUse) begin
                  stallF = 1'b1;
                  stallD = 1'b1;
                  flushE = 1'b1;
               end
            end
            MEMWAIT: begin
               {stallF, stallD, stallE, stallM, flushW} = 5'b11111;
            end
            FLUSH: begin
               if (memMiss)
                  {stallF, stallD, stallE, stallM, flushW} = 5'b11111;
               else
                  flushD = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // State machine: memory wait with timeout, and multi-cycle branch flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= RUN;
         waitCnt     <= '0;
         flushCntInt <= '0;
         memtimeout  <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (memMiss) begin
                  state   <= MEMWAIT;
                  waitCnt <= 8'd1;
               end else if (isbranchtakenE && (FLUSH_CYCLES > 1)) begin
                  state       <= FLUSH;
                  flushCntInt <= 3'(FLUSH_CYCLES - 1);
               end
            end
            MEMWAIT: begin
               if (memreadyM) begin
                  state <= RUN;
               end else if (waitCnt == 8'(MEM_TIMEOUT - 1)) begin
                  memtimeout <= 1'b1;
                  state      <= RUN;
               end else begin
                  waitCnt <= waitCnt + 8'd1;
               end
            end
            FLUSH: begin
               if (memMiss) begin
                  // Branch target is already fetched; remaining flush cycles are dropped.
                  state       <= MEMWAIT;
                  waitCnt     <= 8'd1;
                  flushCntInt <= '0;
               end else begin
                  flushCntInt <= flushCntInt - 3'd1;
                  if (flushCntInt == 3'd1)
                     state <= RUN;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic             branchFlushRun;
   logic [CNT_W-1:0] stallCntQ;
   logic [CNT_W-1:0] flushCntQ;

   assign branchFlushRun = (state == RUN) && !memMiss && isbranchtakenE;

   // Saturating counters of fetch-stall cycles and RUN-state branch flushes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stallCntQ <= '0;
         flushCntQ <= '0;
      end else begin
         if (stallF && (stallCntQ != '1))
            stallCntQ <= stallCntQ + 1'b1;
         if (branchFlushRun && (flushCntQ != '1))
            flushCntQ <= flushCntQ + 1'b1;
      end
   end

   assign stallcnt = stallCntQ;
   assign flushcnt = flushCntQ;
`else
   assign stallcnt = '0;
   assign flushcnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_v2.sv
// tb/tb_hazard_ctrl_v2.sv - directed vector bench for hazard_ctrl_v2
module tb_hazard_ctrl_v2;

   localparam int REG_AW = 5;
   localparam int CNT_W  = 32;
`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic [REG_AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
   logic              regwriteE, isloadE, regwriteM, isloadM, regwriteW;
   logic              isbranchtakenE, memreqM, memreadyM;
   logic [1:0]        forwardaE, forwardbE;
   logic              stallF, stallD, stallE, stallM;
   logic              flushD, flushE, flushW, memtimeout;
   logic [CNT_W-1:0]  stallcnt, flushcnt;

   int total = 0;
   int bad   = 0;

   hazard_ctrl_v2 #(
      .REG_AW(REG_AW), .FLUSH_CYCLES(3), .MEM_TIMEOUT(16), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
      .regwriteE(regwriteE), .isloadE(isloadE),
      .rdM(rdM), .regwriteM(regwriteM), .isloadM(isloadM),
      .rdW(rdW), .regwriteW(regwriteW),
      .isbranchtakenE(isbranchtakenE), .memreqM(memreqM), .memreadyM(memreadyM),
      .forwardaE(forwardaE), .forwardbE(forwardbE),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
      .flushD(flushD), .flushE(flushE), .flushW(flushW),
      .memtimeout(memtimeout), .stallcnt(stallcnt), .flushcnt(flushcnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE;
      logic       regwriteE, isloadE;
      logic [4:0] rdM;
      logic       regwriteM, isloadM;
      logic [4:0] rdW;
      logic       regwriteW;
      logic [1:0] expFa, expFb;
      logic       expStall, expFlushE;
   } vecT;

   vecT vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic clearIn();
      {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
      {regwriteE, isloadE, regwriteM, isloadM, regwriteW} = '0;
      {isbranchtakenE, memreqM, memreadyM} = '0;
   endtask

   task automatic driveVec(input vecT v);
      rs1D = v.rs1D; rs2D = v.rs2D; rs1E = v.rs1E; rs2E = v.rs2E; rdE = v.rdE;
      regwriteE = v.regwriteE; isloadE = v.isloadE;
      rdM = v.rdM; regwriteM = v.regwriteM; isloadM = v.isloadM;
      rdW = v.rdW; regwriteW = v.regwriteW;
   endtask

   initial begin
      int stallCycles;
      int firstFree;
      //             rs1D   rs2D   rs1E   rs2E   rdE   wE    ldE   rdM   wM    ldM   rdW   wW    fa     fb     st    fE
      vecs[0]  = '{5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0};
      vecs[1]  = '{5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 5'd3, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0};
      vecs[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 5'd0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
      vecs[3]  = '{5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0};
      vecs[4]  = '{5'd0, 5'd0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0};
      vecs[5]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
      vecs[6]  = '{5'd0, 5'd8, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};
      vecs[7]  = '{5'd0, 5'd8, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
      vecs[8]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
      vecs[9]  = '{5'd8, 5'd0, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
      vecs[10] = '{5'd8, 5'd0, 5'd0, 5'd0, 5'd8, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
      vecs[11] = '{5'd8, 5'd0, 5'd7, 5'd6, 5'd8, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 5'd7, 1'b1, 2'b01, 2'b10, 1'b1, 1'b1};

      // Reset: outputs forced quiet even with hazard-provoking inputs present.
      clearIn();
      rst = 1'b0;
      @(negedge clk);
      driveVec(vecs[11]);
      isbranchtakenE = 1'b1;
      memreqM = 1'b1;
      #2;
      check("rst_fwdA", 32'(forwardaE), 32'd0);
      check("rst_fwdB", 32'(forwardbE), 32'd0);
      check("rst_stalls", 32'({stallF, stallD, stallE, stallM}), 32'd0);
      check("rst_flushes", 32'({flushD, flushE, flushW}), 32'd0);
      check("rst_memtimeout", 32'(memtimeout), 32'd0);
      check("rst_stallcnt", stallcnt, 32'd0);
      check("rst_flushcnt", flushcnt, 32'd0);
      @(negedge clk);
      clearIn();
      rst = 1'b1;

      // Forwarding and load-use vectors, one clock each in RUN.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         driveVec(vecs[i]);
         #2;
         check($sformatf("vec%0d_fwdA", i), 32'(forwardaE), 32'(vecs[i].expFa));
         check($sformatf("vec%0d_fwdB", i), 32'(forwardbE), 32'(vecs[i].expFb));
         check($sformatf("vec%0d_stallF", i), 32'(stallF), 32'(vecs[i].expStall));
         check($sformatf("vec%0d_stallD", i), 32'(stallD), 32'(vecs[i].expStall));
         check($sformatf("vec%0d_flushE", i), 32'(flushE), 32'(vecs[i].expFlushE));
         check($sformatf("vec%0d_stallEM", i), 32'({stallE, stallM}), 32'd0);
      end

      // Branch with a coincident load-use: flushD for 3 cycles, flushE only first, no stall.
      @(negedge clk);
      clearIn();
      isbranchtakenE = 1'b1;
      rdE = 5'd8; rs2D = 5'd8; isloadE = 1'b1; regwriteE = 1'b1;
      #2;
      check("br0_flushDE", 32'({flushD, flushE}), 32'b11);
      check("br0_stall", 32'({stallF, stallD}), 32'b00);
      @(negedge clk);
      isbranchtakenE = 1'b0;
      #2;
      check("br1_flushDE", 32'({flushD, flushE}), 32'b10);
      check("br1_stall", 32'({stallF, stallD}), 32'b00);
      @(negedge clk);
      clearIn();
      #2;
      check("br2_flushDE", 32'({flushD, flushE}), 32'b10);
      @(negedge clk);
      #2;
      check("br3_flushDE", 32'({flushD, flushE}), 32'b00);

      // Memory wait: ready low for 4 cycles, high on the 5th -> 5 stall cycles.
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         memreqM   = (c == 0);
         memreadyM = (c == 4);
         #2;
         check($sformatf("mw%0d_stall", c), 32'({stallF, stallD, stallE, stallM, flushW}),
               (c < 5) ? 32'b11111 : 32'b00000);
         check($sformatf("mw%0d_flushDE", c), 32'({flushD, flushE}), 32'd0);
      end
      check("mw_memtimeout", 32'(memtimeout), 32'd0);
      check("perf_stallcnt_a", stallcnt, PERF ? 32'd7 : 32'd0);
      check("perf_flushcnt_a", flushcnt, PERF ? 32'd1 : 32'd0);

      // Timeout: ready never arrives -> forced release after 16 stall cycles.
      clearIn();
      stallCycles = 0;
      firstFree   = -1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         memreqM = (c == 0);
         #2;
         if (stallF) stallCycles++;
         else if (firstFree < 0) firstFree = c;
      end
      check("to_stall_cycles", 32'(stallCycles), 32'd16);
      check("to_release_cycle", 32'(firstFree), 32'd16);
      check("to_memtimeout_sticky", 32'(memtimeout), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("to_memtimeout_rst", 32'(memtimeout), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Branch arriving during MEMWAIT waits for the first RUN cycle.
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         memreqM        = (c == 0);
         memreadyM      = (c == 2);
         isbranchtakenE = (c <= 3);
         #2;
         check($sformatf("pr%0d_stallF", c), 32'(stallF), (c < 3) ? 32'd1 : 32'd0);
         check($sformatf("pr%0d_flushDE", c), 32'({flushD, flushE}),
               (c < 3) ? 32'b00 : (c == 3) ? 32'b11 : (c < 6) ? 32'b10 : 32'b00);
      end
      check("perf_stallcnt_b", stallcnt, PERF ? 32'd3 : 32'd0);
      check("perf_flushcnt_b", flushcnt, PERF ? 32'd1 : 32'd0);

      // Reset asserted mid-MEMWAIT drops the stalls without waiting for a clock.
      clearIn();
      @(negedge clk);
      memreqM = 1'b1;
      #2;
      check("ar0_stallF", 32'(stallF), 32'd1);
      @(negedge clk);
      memreqM = 1'b0;
      #2;
      check("ar1_stallF", 32'(stallF), 32'd1);
      #1;
      rst = 1'b0;
      #1;
      check("ar_async_stalls", 32'({stallF, stallD, stallE, stallM, flushW}), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #2;
      check("ar_after_stallF", 32'(stallF), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
